// File: rtl/key_schedule_ctrl_pkg.sv
// key_schedule_ctrl_pkg
// Shared types and constants for the AES-128 key-schedule controller:
// round count, key width, FSM state enum, round-key store type, the AES
// S-box table and the Rcon lookup used by key_round_step.
package key_schedule_ctrl_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_NK_BITS = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [AES_NK_BITS-1:0] round_key_t;
  typedef round_key_t key_store_t [AES_NR+1];

  // S-box flattened with entry 0x00 in the top byte.
  localparam logic [2047:0] AES_SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Entry b lives at byte position 255-b, i.e. ~b for an 8-bit index.
    return AES_SBOX_FLAT[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_round_step.sv
// key_round_step
// One AES-128 key-expansion round: RotWord/SubWord on the last word, Rcon
// XOR, then the four-word XOR chain. The S-box result passes through
// SBOX_LAT register stages, so key_out is valid SBOX_LAT cycles after
// key_in/rnd become stable (both must be held for that long).
// Ports:
//   clk, rst  - clock, async active-high reset
//   key_in    - previous round key
//   rnd       - round index 0..9 (selects Rcon)
//   key_out   - next round key
module key_round_step
  import key_schedule_ctrl_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic [3:0]   rnd,
  output logic [127:0] key_out
);

  logic [31:0] rot_word;
  logic [31:0] sub_pipe [SBOX_LAT];
  logic [31:0] temp;
  logic [31:0] w0, w1, w2, w3;

  assign rot_word = {key_in[23:0], key_in[31:24]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SBOX_LAT; i++) sub_pipe[i] <= '0;
    end else begin
      sub_pipe[0] <= sub_word(rot_word);
      for (int i = 1; i < SBOX_LAT; i++) sub_pipe[i] <= sub_pipe[i-1];
    end
  end

  // Rcon is applied after the pipeline; rnd is held for the whole round.
  assign temp = sub_pipe[SBOX_LAT-1] ^ {rcon(rnd), 24'h000000};
  assign w0   = key_in[127:96] ^ temp;
  assign w1   = key_in[95:64]  ^ w0;
  assign w2   = key_in[63:32]  ^ w1;
  assign w3   = key_in[31:0]   ^ w2;

  assign key_out = {w0, w1, w2, w3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
// Expands an AES-128 key into 11 round keys using one shared round-step
// instance, storing them for random-access read-out.
// Ports:
//   clk, rst   - clock, async active-high reset
//   start      - one-cycle expansion request (IDLE only), key_in sampled then
//   key_in     - 128-bit cipher key
//   busy       - expansion in progress
//   done       - one-cycle pulse when all round keys are stored
//   key_valid  - store holds a complete schedule
//   rd_addr    - round-key index 0..10 (11..15 read as zero)
//   rd_key     - round key at rd_addr
// Build option: KEY_SCHEDULE_RDREG_EN registers rd_key (one-cycle read latency).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | stepping rounds, SBOX_LAT+1 cycles each
// DONE  | one-cycle done pulse, schedule marked valid
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);

  localparam int WCW = (SBOX_LAT < 2) ? 1 : $clog2(SBOX_LAT + 1);

  state_t           state, state_nxt;
  logic [3:0]       rnd;
  logic [WCW-1:0]   wait_cnt;
  round_key_t       cur;
  key_store_t       store;
  logic [127:0]     step_key;
  logic             step_hit;
  logic             accept;
  logic [127:0]     rd_sel;

  key_round_step #(.SBOX_LAT(SBOX_LAT)) u_step (
    .clk     (clk),
    .rst     (rst),
    .key_in  (cur),
    .rnd     (rnd),
    .key_out (step_key)
  );

  assign step_hit = (wait_cnt == WCW'(SBOX_LAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (step_hit && rnd == 4'(AES_NR - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd       <= '0;
      wait_cnt  <= '0;
      cur       <= '0;
      key_valid <= 1'b0;
      for (int i = 0; i <= AES_NR; i++) store[i] <= '0;
    end else if (accept) begin
      store[0]  <= key_in;
      cur       <= key_in;
      rnd       <= '0;
      wait_cnt  <= '0;
      key_valid <= 1'b0;
    end else if (state == ST_RUN) begin
      if (step_hit) begin
        // rnd <= 9 while running, so rnd+1 stays within the 11-entry store.
        store[rnd + 4'd1] <= step_key;
        cur               <= step_key;
        rnd               <= rnd + 4'd1;
        wait_cnt          <= '0;
      end else begin
        wait_cnt <= wait_cnt + WCW'(1);
      end
    end else if (state == ST_DONE) begin
      key_valid <= 1'b1;
    end
  end

  assign rd_sel = (rd_addr <= 4'(AES_NR)) ? store[rd_addr] : '0;

`ifdef KEY_SCHEDULE_RDREG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_key <= '0;
    else     rd_key <= rd_sel;
  end
`else
  assign rd_key = rd_sel;
`endif

endmodule

// File: tb/tb_key_schedule_ctrl.sv
module tb_key_schedule_ctrl;

  localparam int LAT     = 1;
  localparam int EXP_LAT = 10 * (LAT + 1) + 1;
  localparam int BUDGET  = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, key_valid;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [7:0]   ref_sbox [256];
  logic [127:0] model_rk [11];

  typedef struct {
    logic [127:0] key;
    logic [3:0]   addr;
    logic [127:0] exp;
  } vec_t;

  key_schedule_ctrl #(.SBOX_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_addr   (rd_addr),
    .rd_key    (rd_key)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: GF(2^8) arithmetic and the FIPS-197 word recurrence.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      ref_sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
        t[31:24] ^= rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Read after an edge so both combinational and registered read paths settle.
  task automatic read_check(input logic [3:0] addr, input logic [127:0] exp, input string name);
    @(negedge clk);
    rd_addr = addr;
    @(posedge clk);
    #1;
    chk(name, rd_key, exp);
  endtask

  // Start an expansion; optionally pulse a second start (with a different key)
  // at cycle restart_at of the run.
  task automatic expand(input logic [127:0] k, input int restart_at, input string tag);
    int n, d0;
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    d0     = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    chk({tag, " busy_after_start"}, 128'(busy), 128'd1);
    chk({tag, " key_valid_cleared"}, 128'(key_valid), 128'd0);
    while (!done && n < BUDGET) begin
      if (n == restart_at) begin
        start  = 1'b1;
        key_in = ~k;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk({tag, " done_latency"}, 128'(n), 128'(EXP_LAT));
    chk({tag, " busy_in_done"}, 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    chk({tag, " done_one_cycle"}, 128'(done), 128'd0);
    chk({tag, " key_valid_set"}, 128'(key_valid), 128'd1);
    chk({tag, " done_pulse_count"}, 128'(done_cnt - d0), 128'd1);
  endtask

  vec_t vecs [10];
  logic [127:0] k1;

  initial begin
    logic [127:0] last_key;
    logic         have_key;

    rst = 1'b1; start = 1'b0; key_in = '0; rd_addr = '0;
    build_sbox();
    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    vecs[0] = '{k1, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{k1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{k1, 4'd0,  k1};
    vecs[3] = '{k1, 4'd11, 128'h0};
    vecs[4] = '{k1, 4'd15, 128'h0};
    vecs[5] = '{128'h0, 4'd1,  128'h62636363626363636263636362636363};
    vecs[6] = '{128'h0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[7] = '{128'h0, 4'd0,  128'h0};
    vecs[8] = '{128'h0, 4'd11, 128'h0};
    vecs[9] = '{k1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 128'(busy), 128'd0);
    chk("reset done", 128'(done), 128'd0);
    chk("reset key_valid", 128'(key_valid), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    read_check(4'd0, 128'h0, "reset store0");
    read_check(4'd10, 128'h0, "reset store10");

    have_key = 1'b0;
    last_key = '0;
    for (int i = 0; i < 10; i++) begin
      if (!have_key || vecs[i].key !== last_key) begin
        expand(vecs[i].key, 0, "vec");
        last_key = vecs[i].key;
        have_key = 1'b1;
      end
      read_check(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d addr%0d", i, vecs[i].addr));
    end

    // Second start during RUN must be ignored.
    expand(k1, 5, "restart");
    read_check(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "restart rk1");
    read_check(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart rk10");
    read_check(4'd0, k1, "restart rk0");

    // Reset at cycle +8 aborts the run.
    begin
      int d0;
      @(negedge clk);
      key_in = 128'h00112233445566778899aabbccddeeff;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort busy", 128'(busy), 128'd0);
      chk("abort key_valid", 128'(key_valid), 128'd0);
      chk("abort done", 128'(done), 128'd0);
      for (int a = 0; a < 16; a++) read_check(4'(a), 128'h0, $sformatf("abort rd%0d", a));
      @(negedge clk);
      rst = 1'b0;
      d0 = done_cnt;
      repeat (30) @(posedge clk);
      #1;
      chk("abort no_done", 128'(done_cnt - d0), 128'd0);
      chk("abort idle busy", 128'(busy), 128'd0);
      expand(k1, 0, "post_abort");
      read_check(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "post_abort rk1");
      read_check(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_abort rk10");
    end

    // Random keys against the reference model.
    for (int t = 0; t < 6; t++) begin
      logic [127:0] rk;
      rk = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rk);
      expand(rk, (t % 2 == 1) ? int'($urandom_range(2, 18)) : 0, "rand");
      for (int r = 0; r < 11; r++) read_check(4'(r), model_rk[r], $sformatf("rand%0d rk%0d", t, r));
      read_check(4'($urandom_range(11, 15)), 128'h0, $sformatf("rand%0d oob", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 Parameter SBOX_LAT, default 1: cycles from the round-step input being stable to its output being valid (clocked S-box lookup).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to expand key_in; sampled only in IDLE.
REQ-005 key_in  input  128  AES-128 cipher key, sampled in the cycle start is accepted.
REQ-006 busy  output  1  high from the cycle after start acceptance until done.
REQ-007 done  output  1  one-cycle pulse when all 11 round keys are stored.
REQ-008 key_valid  output  1  high while the store holds a complete schedule.
REQ-009 rd_addr  input  4  round-key index 0..10.
REQ-010 rd_key  output  128  round key at rd_addr.

Function
REQ-011 FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start.
- RUN -> DONE after round 9 is captured.
- DONE -> IDLE unconditionally after one cycle.
REQ-012 On start acceptance:
- store[0] <= key_in, cur <= key_in, rnd <= 0, wait_cnt <= 0.
- key_valid <= 0.
REQ-013 In RUN, the round-step instance is driven with cur and rnd; wait_cnt increments each cycle.
REQ-014 When wait_cnt == SBOX_LAT:
- store[rnd+1] <= step output, cur <= step output.
- rnd <= rnd+1, wait_cnt <= 0.
REQ-015 Each round takes SBOX_LAT+1 cycles; done asserts exactly 10*(SBOX_LAT+1)+1 cycles after the start cycle (21 with default).
REQ-016 In DONE: done = 1, busy = 0, key_valid <= 1 (visible from the next cycle, held until the next start or rst).
REQ-017 start while in RUN or DONE is ignored with no effect on rnd, cur or the store.
REQ-018 rd_key is combinational from store[rd_addr] (no configuration macro); rd_addr 11..15 returns all zeros.
REQ-019 rd_key for indices already written during RUN returns the new value; reads of unwritten indices return the prior contents and are not guaranteed coherent until key_valid.
REQ-020 rnd is 4 bits and never exceeds 10; round constants are selected by rnd 0..9 inside the round step.

Reset
REQ-021 rst asserted: state = IDLE, busy = 0, done = 0, key_valid = 0, rnd = 0, wait_cnt = 0, cur = 0, all 11 store entries = 0.
REQ-022 rst mid-RUN aborts the expansion; no done pulse follows, and the next start begins a fresh expansion.

Configuration
REQ-023 Macro KEY_SCHEDULE_RDREG_EN.
- Defined: rd_key is registered; data for rd_addr appears one cycle later; rd_key resets to 0.
- Undefined: rd_key behaves as in REQ-018.

Structure
REQ-024 A shared package holds:
- AES_NR = 10 and AES_NK_BITS = 128.
- The FSM state enum.
- The round-key store type (11 x 128).
REQ-025 Exactly one sub-module, key_round_step (one AES-128 key-expansion round: RotWord/SubWord/Rcon/XOR chain, clocked S-boxes), instantiated once and reused every round.

Verification
REQ-026 key_in = 2b7e151628aed2a6abf7158809cf4f3c, start -> done at cycle +21; rd_addr 1 -> a0fafe1788542cb123a339392a6c7605; rd_addr 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-027 key_in = 0, start -> rd_addr 1 -> 62636363626363636263636362636363; rd_addr 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-028 Second start pulsed at cycle +5 during RUN -> ignored; results identical to REQ-026, single done pulse.
REQ-029 rst asserted at cycle +8 -> busy = 0, key_valid = 0, rd_key = 0 for all addresses; new start then completes correctly.
REQ-030 rd_addr = 11 and 15 with key_valid = 1 -> rd_key = 0; with KEY_SCHEDULE_RDREG_EN defined, the REQ-026 values appear one cycle after rd_addr changes.
